// File: rtl/adc_sample_filter_if.sv
// Sample/result bundle between the ADC SPI master side and the audio filter.
// master drives the ADC word, valid level and enable; slave returns the audio result.
interface adc_sample_filter_if;
  logic        en;
  logic [11:0] i_data;
  logic        i_data_valid;
  logic [15:0] o_audio;
  logic        o_valid;
  logic        o_stale;
  logic        o_primed;

  modport master (
    output en, i_data, i_data_valid,
    input  o_audio, o_valid, o_stale, o_primed
  );

  modport slave (
    input  en, i_data, i_data_valid,
    output o_audio, o_valid, o_stale, o_primed
  );
endinterface

// File: rtl/adc_sample_filter.sv
// Edge-detects ADC conversions, boxcar-averages 2^AVG_LOG2 samples and maps the
// mid-scale code to signed 16-bit audio; a watchdog silences a stalled input.
module adc_sample_filter #(
  parameter int AVG_LOG2 = 2,
  parameter int MIDPOINT = 2048,
  parameter int TIMEOUT  = 5400
) (
  input  logic clk,
  input  logic reset,
  adc_sample_filter_if.slave bus
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = 12 + AVG_LOG2;
  localparam int PTR_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
  localparam logic [15:0]       WD_LIMIT  = 16'(TIMEOUT);
  localparam logic [15:0]       WD_LAST   = 16'(TIMEOUT - 1);

  localparam logic signed [16:0] MID_S   = 17'(MIDPOINT);
  localparam logic signed [16:0] SAT_MAX = 17'sd32767;
  localparam logic signed [16:0] SAT_MIN = -17'sd32768;

  logic              prev_valid;
  logic              accept;
  logic              s1_vld;
  logic [11:0]       s1_data;
  logic              s2_vld;

  logic [11:0]       ring [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [SUM_W-1:0]  sum;
  logic [FILL_W-1:0] fill;
  logic              primed;

  logic [15:0]       wd_cnt;
  logic [15:0]       audio;
  logic              valid;
  logic              stale;

  logic [11:0]        avg;
  logic signed [16:0] diff;
  logic signed [16:0] scaled;
  logic [15:0]        sat;

  assign accept = bus.i_data_valid & ~prev_valid & bus.en;

  // prev_valid resets high so a level already present at reset release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_valid <= 1'b1;
      s1_vld     <= 1'b0;
      s1_data    <= '0;
    end else begin
      prev_valid <= bus.i_data_valid;
      s1_vld     <= accept;
      if (accept) begin
        s1_data <= bus.i_data;
      end
    end
  end

  assign ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;

  // Stage 1: ring write and running sum (modular add/sub keeps the sum exact)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
      fill   <= '0;
      primed <= 1'b0;
      s2_vld <= 1'b0;
    end else if (!bus.en) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
      fill   <= '0;
      primed <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        ring[wr_ptr] <= s1_data;
        wr_ptr       <= ptr_next;
        sum          <= sum + SUM_W'(s1_data) - SUM_W'(ring[wr_ptr]);
        if (fill != FILL_FULL) begin
          fill <= fill + 1'b1;
        end
        if (fill >= FILL_LAST) begin
          primed <= 1'b1;
        end
      end
    end
  end

  assign avg = sum[SUM_W-1:AVG_LOG2];

  always_comb begin
    diff   = $signed({5'd0, avg}) - MID_S;
    scaled = diff <<< 4;
    sat    = scaled[15:0];
    if (scaled > SAT_MAX) begin
      sat = 16'h7fff;
    end else if (scaled < SAT_MIN) begin
      sat = 16'h8000;
    end
  end

  // Stage 2 and watchdog; a result landing on the timeout clock takes precedence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      audio  <= '0;
      valid  <= 1'b0;
      stale  <= 1'b0;
    end else if (!bus.en) begin
      wd_cnt <= '0;
      audio  <= '0;
      valid  <= 1'b0;
      stale  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + 16'd1;
        if (wd_cnt == WD_LAST) begin
          stale <= 1'b1;
          audio <= '0;
        end
      end
      if (s2_vld) begin
        stale <= 1'b0;
        if (primed) begin
          audio <= sat;
          valid <= 1'b1;
        end
      end
    end
  end

  assign bus.o_audio  = audio;
  assign bus.o_valid  = valid;
  assign bus.o_stale  = stale;
  assign bus.o_primed = primed;

endmodule

// File: doc/adc_sample_filter.md
Name: adc_sample_filter

Overview:
Downstream consumer of the MCP3202 SPI master's 12-bit sample word and its DATA_VALID level flag. It detects each new conversion, applies a 2^AVG_LOG2-tap boxcar moving average, and converts the unsigned mid-scale ADC code to a signed 16-bit audio sample with a one-clock strobe. A watchdog forces silence and flags a stale input if conversions stop arriving (nominal rate: one conversion per 2700 clocks at 135 MHz).

Parameters:
AVG_LOG2, 2, log2 of moving-average depth; legal range 0..4; 0 = pass-through with no averaging.
MIDPOINT, 2048, unsigned ADC code that maps to audio 0.
TIMEOUT, 5400, clocks without an accepted sample before o_stale asserts; legal range 1..65535.

Ports:
clk  in  1  system clock, 135 MHz
reset  in  1  asynchronous, active-high reset
en  in  1  filter enable; low = synchronous flush
i_data  in  12  ADC sample word, stable while i_data_valid is high
i_data_valid  in  1  ADC valid level; high for many clocks per conversion
o_audio  out  16  signed audio sample, two's complement
o_valid  out  1  one-clock strobe: o_audio updated
o_stale  out  1  high = no sample for TIMEOUT clocks; o_audio forced to 0
o_primed  out  1  high once the averaging window has been filled since the last flush

Behaviour:
- Reset (async, active-high): o_audio=0, o_valid=0, o_stale=0, o_primed=0.
- Reset also clears: ring buffer, running sum, fill count, watchdog count, and pipeline flags.
- The registered previous value of i_data_valid resets to 1, so a level that is already high at reset release is never accepted as a sample.
- Sample acceptance: a sample is accepted at clock edge E when i_data_valid=1, prev=0, and en=1. i_data is captured at E.
- A high level of any length yields exactly one sample.
- prev tracks i_data_valid every clock, regardless of en.
- Stage E+1:
  - Write the captured sample into the 2^AVG_LOG2-entry ring at the write pointer, then increment the pointer (wraps modulo depth).
  - sum <= sum + new - evicted entry. Sum width is 12+AVG_LOG2, so it never overflows.
  - Fill count increments, saturating at depth. o_primed <= 1 when the count reaches depth.
- Stage E+2:
  - avg = sum >> AVG_LOG2 (truncating).
  - o_audio <= (avg - MIDPOINT) << 4, computed in 17-bit signed arithmetic, then saturated to the 16-bit range -32768..32767.
  - o_valid=1 for exactly one clock. o_stale <= 0.
  - If not yet primed, o_audio stays 0 and no o_valid pulse is issued.
- Latency: o_valid is high during the cycle following edge E+2.
- Back-to-back samples: edges at most every 2 clocks must be handled without loss. The two stages form a pipeline; a new edge while stage E+1 is busy is still accepted.
- Watchdog:
  - Counter increments each clock while en=1 and resets to 0 at every accepted edge.
  - It saturates at TIMEOUT. On reaching TIMEOUT: o_stale <= 1 and o_audio <= 0, with no o_valid pulse.
  - If an edge and the count reaching TIMEOUT occur on the same clock, the edge wins: counter reset, o_stale not set.
- en low (synchronous flush, every clock while low): ring, sum, fill count and watchdog are cleared, and o_audio, o_valid, o_stale and o_primed go to 0.
  - Edges are ignored while en is low.
  - Samples in flight in the pipeline are discarded.
- Reset asserted mid-pipeline discards everything immediately; no o_valid pulse follows.
- AVG_LOG2=0: one-entry ring; output equals the current sample mapped; o_primed sets on the first sample.

Test Plan:
- Setup for the averaging tests: AVG_LOG2=2, MIDPOINT=2048, en=1, one i_data_valid pulse of 167 clocks per conversion.
- Prime: 4 samples of 2048 -> no o_valid on samples 1-3; sample 4: o_primed=1, o_valid single pulse 2 clocks after edge, o_audio=0.
- Step: after prime, 4 samples of 4095 -> o_audio = 8176, 16368, 24560, 32752, one o_valid pulse each.
- Negative full scale: after flush, 4 samples of 0 -> 4th gives o_audio=-32768 (0x8000).
- Held level / reset: i_data_valid already high when reset deasserts, stays high 500 clocks -> no sample accepted; o_valid stays 0.
- Watchdog: primed, then no edges -> o_stale=1 and o_audio=0 exactly TIMEOUT (5400) clocks after the last accepted edge; the next sample clears o_stale with its o_valid pulse.
- Flush: drop en for 1 clock between samples 2 and 3 of a priming run -> o_primed=0, sum=0; 4 further samples are needed before the next o_valid.
